qspi_mem_arb: RTL

Arbiter and line assembler sitting directly upstream of the `qspi` controller. It accepts cache-line miss requests from the instruction cache and read or write requests from the data cache, and grants one at a time. For the granted request it drives `qspi`'s `req`, `i_d`, `mem`, `write` and `paddr`. It assembles read nibbles into a line for the requester, or serialises a write line into nibbles on `rstrobe_d`.

---
 rtl/qspi_pkg.sv | 26 ++
 rtl/qspi_line_shift.sv | 59 +++++
 rtl/qspi_mem_arb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the qspi memory-side arbiter and its line register.
package qspi_pkg;

    localparam int PA          = 24;
    localparam int LINE_LENGTH = 4;
    localparam int NIB         = 2 * LINE_LENGTH;

    localparam logic DEV_RAM = 1'b0;
    localparam logic DEV_ROM = 1'b1;

    localparam logic SIDE_D = 1'b0;
    localparam logic SIDE_I = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        GAP
    } arb_state_t;

    // Low bit of nibble k inside a line: byte k/2, high nibble first.
    function automatic int nib_lo(input int k);
        return 8 * (k / 2) + (((k % 2) == 1) ? 0 : 4);
    endfunction

endpackage

// File: rtl/qspi_line_shift.sv
// Line register addressed by nibble: whole-line load or single-nibble insert,
// plus a nibble select port. Used for read assembly and as the write source.
module qspi_line_shift #(
    parameter  int NIB = qspi_pkg::NIB,
    localparam int NW  = $clog2(NIB),
    localparam int LW  = 4 * NIB
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [LW-1:0] load_line,
    input  logic          ins_en,
    input  logic [NW-1:0] ins_idx,
    input  logic [3:0]    ins_nib,
    input  logic [NW-1:0] sel_idx,
    output logic [3:0]    sel_nib,
    output logic [LW-1:0] line,
    output logic [LW-1:0] line_next
);
    import qspi_pkg::*;

    logic [LW-1:0] line_q;
    logic [LW-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (load_en) begin
            line_d = load_line;
        end else if (ins_en) begin
            for (int k = 0; k < NIB; k++) begin
                if (ins_idx == NW'(k)) begin
                    line_d[nib_lo(k) +: 4] = ins_nib;
                end
            end
        end
    end

    always_comb begin
        sel_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (sel_idx == NW'(k)) begin
                sel_nib = line_q[nib_lo(k) +: 4];
            end
        end
    end

    // NOTE: the line is a plain register, not a RAM, so it is reset; this is what makes dwrite read 0 out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line      = line_q;
    assign line_next = line_d;

endmodule

// File: rtl/qspi_mem_arb.sv
// Round-robin arbiter between I-cache fills and D-cache reads/writes in front of
// the qspi controller; assembles read nibbles into lines and serialises write lines.
module qspi_mem_arb #(
    parameter  int PA          = qspi_pkg::PA,
    parameter  int LINE_LENGTH = qspi_pkg::LINE_LENGTH,
    localparam int AW          = PA - $clog2(LINE_LENGTH),
    localparam int LW          = 8 * LINE_LENGTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ic_req,
    input  logic          ic_mem,
    input  logic [AW-1:0] ic_paddr,
    output logic          ic_ack,
    output logic [LW-1:0] ic_rline,
    input  logic          dc_req,
    input  logic          dc_write,
    input  logic          dc_mem,
    input  logic [AW-1:0] dc_paddr,
    input  logic [LW-1:0] dc_wline,
    output logic          dc_ack,
    output logic [LW-1:0] dc_rline,
    output logic          req,
    output logic          i_d,
    output logic          mem,
    output logic          write,
    output logic [AW-1:0] paddr,
    input  logic          wstrobe_i,
    input  logic          wstrobe_d,
    input  logic          rstrobe_d,
    output logic [3:0]    dwrite,
    input  logic [3:0]    qspi_din
);
    import qspi_pkg::*;

    localparam int NIB = 2 * LINE_LENGTH;
    localparam int NW  = $clog2(NIB);

    arb_state_t    state_q,    state_d;
    logic          req_q,      req_d;
    logic          i_d_q,      i_d_d;
    logic          mem_q,      mem_d;
    logic          write_q,    write_d;
    logic          last_q,     last_d;
    logic          ic_ack_q,   ic_ack_d;
    logic          dc_ack_q,   dc_ack_d;
    logic [AW-1:0] paddr_q,    paddr_d;
    logic [NW-1:0] nib_q,      nib_d;
    logic [LW-1:0] ic_rline_q, ic_rline_d;
    logic [LW-1:0] dc_rline_q, dc_rline_d;

    logic          grant_i;
    logic          grant_d;
    logic          rd_stb;
    logic          wr_stb;
    logic          last_nib;
    logic          wsrc_load;
    logic [LW-1:0] asm_line_next;
    logic [3:0]    unused_asm_nib;
    logic [LW-1:0] unused_asm_line;
    logic [LW-1:0] unused_wsrc_line;
    logic [LW-1:0] unused_wsrc_next;

    // The side not granted last wins a tie; last_q resets to D so I wins first.
    assign grant_i   = ic_req && (!dc_req || (last_q == SIDE_D));
    assign grant_d   = dc_req && !grant_i;
    assign rd_stb    = (state_q == RD) && (i_d_q ? wstrobe_i : wstrobe_d);
    assign wr_stb    = (state_q == WR) && rstrobe_d;
    assign last_nib  = (nib_q == NW'(NIB - 1));
    assign wsrc_load = (state_q == IDLE) && grant_d;

    qspi_line_shift #(.NIB(NIB)) u_rd_asm (
        .clk       (clk),
        .reset     (reset),
        .load_en   (1'b0),
        .load_line ('0),
        .ins_en    (rd_stb),
        .ins_idx   (nib_q),
        .ins_nib   (qspi_din),
        .sel_idx   (nib_q),
        .sel_nib   (unused_asm_nib),
        .line      (unused_asm_line),
        .line_next (asm_line_next)
    );

    qspi_line_shift #(.NIB(NIB)) u_wr_src (
        .clk       (clk),
        .reset     (reset),
        .load_en   (wsrc_load),
        .load_line (dc_wline),
        .ins_en    (1'b0),
        .ins_idx   ('0),
        .ins_nib   ('0),
        .sel_idx   (nib_q),
        .sel_nib   (dwrite),
        .line      (unused_wsrc_line),
        .line_next (unused_wsrc_next)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        i_d_d      = i_d_q;
        mem_d      = mem_q;
        write_d    = write_q;
        last_d     = last_q;
        paddr_d    = paddr_q;
        nib_d      = nib_q;
        ic_rline_d = ic_rline_q;
        dc_rline_d = dc_rline_q;
        ic_ack_d   = 1'b0;
        dc_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_i || grant_d) begin
                    i_d_d   = grant_i;
                    last_d  = grant_i;
                    mem_d   = grant_i ? ic_mem : dc_mem;
                    paddr_d = grant_i ? ic_paddr : dc_paddr;
                    write_d = grant_d && dc_write;
                    req_d   = 1'b1;
                    nib_d   = '0;
                    state_d = (grant_d && dc_write) ? WR : RD;
                end
            end
            RD: begin
                if (rd_stb) begin
                    nib_d = nib_q + NW'(1);
                    if (last_nib) begin
                        req_d   = 1'b0;
                        state_d = GAP;
                        // The copy includes the nibble being written on this same edge.
                        if (i_d_q) begin
                            ic_ack_d   = 1'b1;
                            ic_rline_d = asm_line_next;
                        end else begin
                            dc_ack_d   = 1'b1;
                            dc_rline_d = asm_line_next;
                        end
                    end
                end
            end
            WR: begin
                if (wr_stb) begin
                    nib_d = nib_q + NW'(1);
                    if (last_nib) begin
                        req_d    = 1'b0;
                        dc_ack_d = 1'b1;
                        state_d  = GAP;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: every flop updates with <= so all of them see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            i_d_q      <= 1'b0;
            mem_q      <= DEV_RAM;
            write_q    <= 1'b0;
            last_q     <= SIDE_D;
            paddr_q    <= '0;
            nib_q      <= '0;
            ic_ack_q   <= 1'b0;
            dc_ack_q   <= 1'b0;
            ic_rline_q <= '0;
            dc_rline_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            i_d_q      <= i_d_d;
            mem_q      <= mem_d;
            write_q    <= write_d;
            last_q     <= last_d;
            paddr_q    <= paddr_d;
            nib_q      <= nib_d;
            ic_ack_q   <= ic_ack_d;
            dc_ack_q   <= dc_ack_d;
            ic_rline_q <= ic_rline_d;
            dc_rline_q <= dc_rline_d;
        end
    end

    assign req      = req_q;
    assign i_d      = i_d_q;
    assign mem      = mem_q;
    assign write    = write_q;
    assign paddr    = paddr_q;
    assign ic_ack   = ic_ack_q;
    assign dc_ack   = dc_ack_q;
    assign ic_rline = ic_rline_q;
    assign dc_rline = dc_rline_q;

endmodule
